// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler
//   Round-robin scheduler that shares one fixed-latency 64x64 multiplier among
//   NREQ requesters. At most one operand pair is accepted per cycle. Operands
//   are masked to the requested width mode before issue. A tag shift register
//   follows every in-flight operation, so the product can be routed back to
//   its owner without any stall.
//
// Build option
//   MULT_RR_PRIO0_EN : when defined, requester 0 has strict priority and
//                      requesters 1..NREQ-1 round-robin among themselves.
//                      When undefined, all requesters are pure round-robin.
//
// Parameters
//   NREQ : number of requesters (2..8)
//   LAT  : multiplier latency; mul_product is valid LAT cycles after mul_valid
//   CNTW : width of the completed-operation counter
//
// Ports
//   clock       : rising-edge clock
//   reset       : synchronous, active-low reset
//   req_valid   : per-requester operand valid
//   req_ready   : one-hot combinational grant (0 while reset is low)
//   req_mode    : per-requester mode, 2 bits each (0,1=32b 2=48b 3=64b)
//   req_a/req_b : per-requester operands, 64 bits each
//   mul_valid   : operands on mul_a/mul_b are valid this cycle
//   mul_a/mul_b : masked operands to the multiplier
//   mul_product : multiplier result, valid LAT cycles after mul_valid
//   rsp_valid   : one-hot response strobe, no backpressure
//   rsp_product : masked product for the strobed requester (holds otherwise)
//   ops_done    : completed-operation count, wraps at 2^CNTW
//   busy        : 1 while any operation is in flight
//
// Handshake: requester i transfers an operand pair in a cycle where
//   req_valid[i] & req_ready[i] is 1. req_ready is only ever set for a
//   requester whose req_valid is already 1, so a grant is an accept. A
//   requester may drop req_valid while not granted; nothing is remembered
//   about requests that were not accepted. Responses have no ready: the owner
//   must take rsp_product in the cycle rsp_valid is set.

module mult_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int LAT  = 3,
    parameter int CNTW = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_mode,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    output logic                 mul_valid,
    output logic [63:0]          mul_a,
    output logic [63:0]          mul_b,
    input  logic [127:0]         mul_product,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [127:0]         rsp_product,
    output logic [CNTW-1:0]      ops_done,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] idx;
        logic [1:0]    mode;
    } tag_t;

    function automatic logic [63:0] mask_op(input logic [63:0] v, input logic [1:0] m);
        case (m)
            2'd2:    return {16'h0, v[47:0]};
            2'd3:    return v;
            default: return {32'h0, v[31:0]};
        endcase
    endfunction

    function automatic logic [127:0] mask_prod(input logic [127:0] v, input logic [1:0] m);
        case (m)
            2'd2:    return {32'h0, v[95:0]};
            2'd3:    return v;
            default: return {64'h0, v[63:0]};
        endcase
    endfunction

    // State
    logic [IW-1:0]   ptr_q,         ptr_d;
    logic            mul_valid_q,   mul_valid_d;
    logic [63:0]     mul_a_q,       mul_a_d;
    logic [63:0]     mul_b_q,       mul_b_d;
    logic [IW-1:0]   iss_idx_q,     iss_idx_d;
    logic [1:0]      iss_mode_q,    iss_mode_d;
    tag_t            tag_q [0:LAT];
    tag_t            tag_d [0:LAT];
    logic [NREQ-1:0] rsp_valid_q,   rsp_valid_d;
    logic [127:0]    rsp_product_q, rsp_product_d;
    logic [CNTW-1:0] ops_done_q,    ops_done_d;

    // Arbitration
    logic [NREQ-1:0] rr_cand;
    logic            grant_any;
    logic [IW-1:0]   grant_idx;

    always_comb begin
        rr_cand = req_valid;
`ifdef MULT_RR_PRIO0_EN
        // Requester 0 is handled by the strict-priority override below.
        rr_cand[0] = 1'b0;
`endif
        grant_any = 1'b0;
        grant_idx = '0;
        // First pass: lowest candidate overall (the wrapped-around choice).
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rr_cand[i]) begin
                grant_any = 1'b1;
                grant_idx = IW'(i);
            end
        end
        // Second pass: lowest candidate at or above the pointer wins if any.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rr_cand[i] && (i >= int'(ptr_q))) begin
                grant_idx = IW'(i);
            end
        end
`ifdef MULT_RR_PRIO0_EN
        if (req_valid[0]) begin
            grant_any = 1'b1;
            grant_idx = '0;
        end
`endif
        if (!reset) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Operand select for the granted requester
    logic [63:0] sel_a;
    logic [63:0] sel_b;
    logic [1:0]  sel_mode;

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_mode = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_a    = req_a[i*64 +: 64];
                sel_b    = req_b[i*64 +: 64];
                sel_mode = req_mode[i*2 +: 2];
            end
        end
    end

    // Next state
    always_comb begin
        ptr_d = ptr_q;
`ifdef MULT_RR_PRIO0_EN
        if (grant_any && (grant_idx != '0)) begin
`else
        if (grant_any) begin
`endif
            if (grant_idx == IW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end

        mul_valid_d = grant_any;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        iss_idx_d   = iss_idx_q;
        iss_mode_d  = iss_mode_q;
        if (grant_any) begin
            mul_a_d    = mask_op(sel_a, sel_mode);
            mul_b_d    = mask_op(sel_b, sel_mode);
            iss_idx_d  = grant_idx;
            iss_mode_d = sel_mode;
        end

        // Stage k of the tag pipe is valid LAT cycles... aligned so that stage
        // LAT-1 coincides with mul_product and stage LAT with rsp_valid.
        tag_d[0] = {mul_valid_q, iss_idx_q, iss_mode_q};
        for (int k = 1; k <= LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        rsp_valid_d   = '0;
        rsp_product_d = rsp_product_q;
        ops_done_d    = ops_done_q;
        if (tag_q[LAT-1].valid) begin
            rsp_valid_d[tag_q[LAT-1].idx] = 1'b1;
            rsp_product_d = mask_prod(mul_product, tag_q[LAT-1].mode);
            // Counted together with the strobe so ops_done includes it.
            ops_done_d    = ops_done_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q         <= '0;
            mul_valid_q   <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            iss_idx_q     <= '0;
            iss_mode_q    <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            ops_done_q    <= '0;
        end else begin
            ptr_q         <= ptr_d;
            mul_valid_q   <= mul_valid_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            iss_idx_q     <= iss_idx_d;
            iss_mode_q    <= iss_mode_d;
            for (int k = 0; k <= LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            ops_done_q    <= ops_done_d;
        end
    end

    // busy covers issue through the response cycle, so it drops the cycle
    // after the last rsp_valid.
    always_comb begin
        busy = mul_valid_q;
        for (int k = 0; k <= LAT; k++) begin
            busy = busy | tag_q[k].valid;
        end
    end

    assign mul_valid   = mul_valid_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign ops_done    = ops_done_q;

endmodule
